// File: rtl/pc_sequencer.sv
// Program-counter and status-register stage downstream of the ALU.
// Runs IDLE -> RUN -> DONE, steering fetch through a small branch-target table.
module pc_sequencer #(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_addr,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] target_sel,
  input  logic                 alu_branch,
  input  logic                 flag_we,
  input  logic                 alu_flag,
  input  logic                 flip_we,
  input  logic                 alu_flip,
  output logic [PC_W-1:0]      pc,
  output logic                 flag,
  output logic                 flip,
  output logic                 running,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int LUT_DEPTH = 2 ** LUT_IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic             flag_reg, flag_next;
  logic             flip_reg, flip_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PC_W-1:0]  lut_mem [LUT_DEPTH];

  // Table lives in flops: it must clear on reset and be read in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_mem[i] <= '0;
    end else if (state_reg == IDLE && lut_we) begin
      lut_mem[lut_waddr] <= lut_wdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flag_next  = flag_reg;
    flip_next  = flip_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = start_addr;
          cnt_next   = '0;
          flag_next  = 1'b0;
          flip_next  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
        // Stall freezes everything except the cycle counter.
        if (!stall) begin
          if (flag_we) flag_next = alu_flag;
          if (flip_we) flip_next = alu_flip;
          if (halt) begin
            state_next = DONE;
          end else if (branch_en && alu_branch) begin
            pc_next = lut_mem[target_sel];
          end else begin
            pc_next = pc_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      flag_reg  <= 1'b0;
      flip_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      flag_reg  <= flag_next;
      flip_reg  <= flip_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign pc          = pc_reg;
  assign flag        = flag_reg;
  assign flip        = flip_reg;
  assign cycle_count = cnt_reg;
  assign running     = (state_reg == RUN);
  assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with a 4-bit counter
// shares the stimulus to exercise counter saturation.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, lut_we, stall, halt, branch_en, alu_branch;
  logic       flag_we, alu_flag, flip_we, alu_flip;
  logic [9:0] start_addr, lut_wdata;
  logic [3:0] lut_waddr, target_sel;

  logic [9:0]  pc, pc4;
  logic        flag, flip, running, done, flag4, flip4, running4, done4;
  logic [15:0] cycle_count;
  logic [3:0]  cycle_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .stall(stall), .halt(halt), .branch_en(branch_en), .target_sel(target_sel),
    .alu_branch(alu_branch), .flag_we(flag_we), .alu_flag(alu_flag),
    .flip_we(flip_we), .alu_flip(alu_flip), .pc(pc), .flag(flag), .flip(flip),
    .running(running), .done(done), .cycle_count(cycle_count)
  );

  pc_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .stall(stall), .halt(halt), .branch_en(branch_en), .target_sel(target_sel),
    .alu_branch(alu_branch), .flag_we(flag_we), .alu_flag(alu_flag),
    .flip_we(flip_we), .alu_flip(alu_flip), .pc(pc4), .flag(flag4), .flip(flip4),
    .running(running4), .done(done4), .cycle_count(cycle_count4)
  );

  typedef struct {
    string       tag;
    logic [9:0]  pc;
    logic        flag, flip, running, done;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  // Expected architectural state after the next clock edge.
  logic [9:0]  e_pc;
  logic        e_flag, e_flip, e_run, e_done;
  int          e_cnt;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    exp_t e, got;
    e.tag     = tag;
    e.pc      = e_pc;
    e.flag    = e_flag;
    e.flip    = e_flip;
    e.running = e_run;
    e.done    = e_done;
    e.cnt     = 16'(e_cnt);
    e.cnt4    = (e_cnt > 15) ? 4'hF : 4'(e_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk(got.tag, "pc", 32'(pc), 32'(got.pc));
    chk(got.tag, "flag", 32'(flag), 32'(got.flag));
    chk(got.tag, "flip", 32'(flip), 32'(got.flip));
    chk(got.tag, "running", 32'(running), 32'(got.running));
    chk(got.tag, "done", 32'(done), 32'(got.done));
    chk(got.tag, "cycle_count", 32'(cycle_count), 32'(got.cnt));
    chk(got.tag, "cycle_count4", 32'(cycle_count4), 32'(got.cnt4));
    $display("step %-14s pc=%03h flag=%0b flip=%0b run=%0b done=%0b cnt=%0d cnt4=%0d",
             got.tag, pc, flag, flip, running, done, cycle_count, cycle_count4);
  endtask

  task automatic clr();
    start = 0; lut_we = 0; stall = 0; halt = 0; branch_en = 0; alu_branch = 0;
    flag_we = 0; alu_flag = 0; flip_we = 0; alu_flip = 0; target_sel = 0;
  endtask

  task automatic branch(input logic [3:0] sel);
    branch_en = 1; alu_branch = 1; target_sel = sel;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    start_addr = 0; lut_waddr = 0; lut_wdata = 0;
    reset = 1;
    e_pc = 0; e_flag = 0; e_flip = 0; e_run = 0; e_done = 0; e_cnt = 0;
    step("rst0");
    step("rst1");
    reset = 0;

    // Straight-line run from 0x005.
    start = 1; start_addr = 10'h005;
    e_pc = 10'h005; e_run = 1; e_cnt = 0;
    step("start5");
    start = 0;
    for (int i = 1; i <= 4; i++) begin
      e_pc = 10'(5 + i); e_cnt = i;
      step("seq");
    end
    halt = 1; e_run = 0; e_done = 1; e_cnt = 5;
    step("halt9");
    halt = 0; e_done = 0;
    step("done_exit");

    // Table loads in IDLE; the last one coincides with start.
    lut_we = 1;
    lut_waddr = 3; lut_wdata = 10'h120; step("lut3");
    lut_waddr = 6; lut_wdata = 10'h040; step("lut6");
    lut_waddr = 7; lut_wdata = 10'h022; step("lut7");
    lut_waddr = 8; lut_wdata = 10'h0A7; step("lut8");
    lut_waddr = 5; lut_wdata = 10'h3FE; start = 1; start_addr = 10'h010;
    e_pc = 10'h010; e_run = 1; e_cnt = 0;
    step("start_lut5");
    clr();

    branch(3); e_pc = 10'h120; e_cnt = 1; step("br_taken");
    alu_branch = 0; e_pc = 10'h121; e_cnt = 2; step("br_not");
    branch_en = 0; alu_branch = 1; e_pc = 10'h122; e_cnt = 3; step("alu_only");
    clr();
    flip_we = 1; alu_flip = 1; alu_flag = 1;
    e_pc = 10'h123; e_flip = 1; e_cnt = 4; step("flip_we");
    clr();
    flag_we = 1; alu_flag = 1;
    e_pc = 10'h124; e_flag = 1; e_cnt = 5; step("flag_we");
    clr();

    // Wrap-around at the top of the address space.
    branch(5); e_pc = 10'h3FE; e_cnt = 6; step("br_3fe");
    clr(); e_pc = 10'h3FF; e_cnt = 7; step("pc_3ff");
    e_pc = 10'h000; e_cnt = 8; step("wrap");

    // Stall at 0x040 overrides every other input.
    branch(6); e_pc = 10'h040; e_cnt = 9; step("br_040");
    clr();
    stall = 1; flag_we = 1; alu_flag = 0; flip_we = 1; alu_flip = 0; halt = 1;
    branch(3);
    for (int i = 1; i <= 3; i++) begin
      e_cnt = 9 + i;
      step("stall");
    end
    clr();

    // Flag write commits on the halt cycle.
    branch(7); flag_we = 1; alu_flag = 0;
    e_pc = 10'h022; e_flag = 0; e_cnt = 13; step("br_022");
    clr();
    halt = 1; flag_we = 1; alu_flag = 1; branch(3);
    e_flag = 1; e_run = 0; e_done = 1; e_cnt = 14; step("halt_flag");
    clr();
    start = 1; start_addr = 10'h1AB; e_done = 0; step("start_in_done");
    clr();
    halt = 1; branch(3); flag_we = 1; alu_flag = 0; flip_we = 1; alu_flip = 0;
    step("idle_ignore");
    clr();

    // Table writes during RUN are dropped.
    start = 1; start_addr = 10'h080;
    e_pc = 10'h080; e_flag = 0; e_flip = 0; e_run = 1; e_cnt = 0; step("start80");
    clr();
    lut_we = 1; lut_waddr = 3; lut_wdata = 10'h2AA;
    e_pc = 10'h081; e_cnt = 1; step("lut_we_run");
    clr();
    branch(3); e_pc = 10'h120; e_cnt = 2; step("old_target");
    branch(8); flag_we = 1; alu_flag = 1; flip_we = 1; alu_flip = 1;
    e_pc = 10'h0A7; e_flag = 1; e_flip = 1; e_cnt = 3; step("br_0a7");
    clr();

    // Reset mid-run clears the table as well.
    reset = 1;
    e_pc = 0; e_flag = 0; e_flip = 0; e_run = 0; e_done = 0; e_cnt = 0;
    step("reset_mid");
    reset = 0;
    start = 1; start_addr = 10'h000; e_run = 1; step("start0");
    clr();
    branch(3); e_pc = 10'h000; e_cnt = 1; step("lut_cleared");
    clr();
    halt = 1; e_run = 0; e_done = 1; e_cnt = 2; step("halt0");
    clr(); e_done = 0; step("idle0");

    // Long run: the 4-bit counter must stick at 0xF.
    start = 1; start_addr = 10'h300;
    e_pc = 10'h300; e_run = 1; e_cnt = 0; step("start300");
    clr();
    for (int i = 1; i <= 20; i++) begin
      e_pc = 10'(10'h300 + i); e_cnt = i;
      step("sat");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
